// File: rtl/multi_channel_counter.sv
`default_nettype none
// ============================================================================
// multi_channel_counter: NUM_CH prescaled counters with per-channel mode,
// PWM compare and sticky maskable event flags. Rev 1.0
// ============================================================================
module multi_channel_counter #(
   parameter int WIDTH      = 8,
   parameter int NUM_CH     = 4,
   parameter int PRESCALE_W = 4,
   parameter int CW         = $clog2(NUM_CH)
) (
   input  logic                    gated_clk,
   input  logic                    rst_n,
   input  logic [PRESCALE_W-1:0]   prescale,
   input  logic [NUM_CH-1:0]       ch_enable,
   input  logic                    cfg_we,
   input  logic [CW-1:0]           cfg_ch,
   input  logic [1:0]              cfg_mode,
   input  logic [WIDTH-1:0]        cfg_step,
   input  logic [WIDTH-1:0]        cfg_reload,
   input  logic [WIDTH-1:0]        cfg_compare,
   input  logic                    cfg_auto_reload,
   input  logic                    load_we,
   input  logic [WIDTH-1:0]        load_value,
   input  logic [NUM_CH*3-1:0]     irq_mask,
   input  logic [NUM_CH*3-1:0]     irq_clear,
   output logic [NUM_CH*WIDTH-1:0] count_flat,
   output logic [NUM_CH*3-1:0]     flags,
   output logic [NUM_CH-1:0]       dir,
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH-1:0]       pwm_out,
   output logic                    irq
);

   localparam logic [1:0] c_mode_up       = 2'b00;
   localparam logic [1:0] c_mode_down     = 2'b01;
   localparam logic [1:0] c_mode_pingpong = 2'b10;

   logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic                  w_tick;

   // Equality compare lets a shrunk prescale wrap through the full range once.
   assign w_tick = (pre_cnt_q == prescale);

   always_comb begin
      pre_cnt_d = w_tick ? '0 : pre_cnt_q + 1'b1;
   end

   always_ff @(posedge gated_clk or negedge rst_n) begin
      if (!rst_n) pre_cnt_q <= '0;
      else        pre_cnt_q <= pre_cnt_d;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [WIDTH-1:0] count_q, count_d, step_q, step_d;
      logic [WIDTH-1:0] reload_q, reload_d, compare_q, compare_d;
      logic [1:0]       mode_q, mode_d;
      logic             auto_reload_q, auto_reload_d;
      logic             dir_q, dir_d, done_q, done_d;
      logic [2:0]       flags_q, flags_d;
      logic [2:0]       w_events;
      logic [WIDTH:0]   w_sum, w_diff;
      logic             w_sel, w_advance;

      assign w_sel     = (cfg_ch == CW'(i));
      assign w_advance = w_tick && ch_enable[i] && !done_q && (step_q != '0);
      // Top bit of w_sum is the carry, top bit of w_diff the borrow.
      assign w_sum     = {1'b0, count_q} + {1'b0, step_q};
      assign w_diff    = {1'b0, count_q} - {1'b0, step_q};

      always_comb begin
         count_d       = count_q;
         step_d        = step_q;
         reload_d      = reload_q;
         compare_d     = compare_q;
         mode_d        = mode_q;
         auto_reload_d = auto_reload_q;
         dir_d         = dir_q;
         done_d        = done_q;
         w_events      = '0;

         if (w_advance) begin
            case (mode_q)
               c_mode_up: begin
                  if (w_sum[WIDTH]) begin
                     w_events[0] = 1'b1;
                     count_d     = auto_reload_q ? reload_q : w_sum[WIDTH-1:0];
                  end else begin
                     count_d = w_sum[WIDTH-1:0];
                  end
               end
               c_mode_down: begin
                  if (w_diff[WIDTH]) begin
                     w_events[1] = 1'b1;
                     count_d     = auto_reload_q ? reload_q : w_diff[WIDTH-1:0];
                  end else begin
                     count_d = w_diff[WIDTH-1:0];
                  end
               end
               c_mode_pingpong: begin
                  if (!dir_q) begin
                     if (w_sum[WIDTH]) begin
                        count_d     = '1;
                        w_events[0] = 1'b1;
                        dir_d       = 1'b1;
                     end else begin
                        count_d = w_sum[WIDTH-1:0];
                     end
                  end else if (w_diff[WIDTH]) begin
                     count_d     = '0;
                     w_events[1] = 1'b1;
                     dir_d       = 1'b0;
                  end else begin
                     count_d = w_diff[WIDTH-1:0];
                  end
               end
               default: begin
                  if (count_q <= step_q) begin
                     count_d     = '0;
                     w_events[1] = 1'b1;
                     done_d      = 1'b1;
                  end else begin
                     count_d = w_diff[WIDTH-1:0];
                  end
               end
            endcase
            if (count_d == compare_q) w_events[2] = 1'b1;
         end

         if (cfg_we && w_sel) begin
            mode_d        = cfg_mode;
            step_d        = cfg_step;
            reload_d      = cfg_reload;
            compare_d     = cfg_compare;
            auto_reload_d = cfg_auto_reload;
            if (cfg_mode != mode_q) begin
               dir_d  = 1'b0;
               done_d = 1'b0;
            end
         end

         // A load overrides any advance on the same edge and suppresses its events.
         if (load_we && w_sel) begin
            count_d  = load_value;
            dir_d    = 1'b0;
            done_d   = 1'b0;
            w_events = '0;
         end

         flags_d = (flags_q & ~irq_clear[3*i +: 3]) | w_events;
      end

      always_ff @(posedge gated_clk or negedge rst_n) begin
         if (!rst_n) begin
            count_q       <= '0;
            step_q        <= WIDTH'(1);
            reload_q      <= '0;
            compare_q     <= '0;
            mode_q        <= c_mode_up;
            auto_reload_q <= 1'b0;
            dir_q         <= 1'b0;
            done_q        <= 1'b0;
            flags_q       <= '0;
         end else begin
            count_q       <= count_d;
            step_q        <= step_d;
            reload_q      <= reload_d;
            compare_q     <= compare_d;
            mode_q        <= mode_d;
            auto_reload_q <= auto_reload_d;
            dir_q         <= dir_d;
            done_q        <= done_d;
            flags_q       <= flags_d;
         end
      end

      assign count_flat[i*WIDTH +: WIDTH] = count_q;
      assign flags[3*i +: 3]              = flags_q;
      assign dir[i]                       = dir_q;
      assign done[i]                      = done_q;
      assign pwm_out[i]                   = (count_q < compare_q);
   end

   assign irq = |(flags & irq_mask);

endmodule
`default_nettype wire

// File: doc/multi_channel_counter.md
# multi_channel_counter

Parametrised NUM_CH-channel successor to the single-channel advanced counter. Each channel has its own mode, step, reload, compare and PWM output. All channels advance on a shared programmable prescaler tick. Sticky event flags with write-1-to-clear feed one maskable interrupt line, which sits between the register bus and the timer/PWM consumers.

## Interface
- WIDTH, 8, counter width in bits per channel (≥2)
- NUM_CH, 4, number of channels (≥2); CW = $clog2(NUM_CH)
- PRESCALE_W, 4, prescaler compare width
- gated_clk  in  1  clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock gated_clk
- prescale  in  PRESCALE_W  tick every prescale+1 cycles
- ch_enable  in  NUM_CH  per-channel advance enable
- cfg_we  in  1  config write strobe
- cfg_ch  in  CW  target channel for cfg_we/load_we
- cfg_mode  in  2  00 up, 01 down, 10 ping-pong, 11 one-shot down
- cfg_step, cfg_reload, cfg_compare  in  WIDTH each  step, reload value, compare value
- cfg_auto_reload  in  1  reload on wrap (modes 00/01)
- load_we  in  1  load strobe; count[cfg_ch] <= load_value
- load_value  in  WIDTH  load data
- irq_mask  in  NUM_CH*3  {match,unf,ovf} enable per channel; ch i at [3i+2:3i]
- irq_clear  in  NUM_CH*3  write-1-to-clear, same layout as irq_mask
- count_flat  out  NUM_CH*WIDTH  channel i at [i*WIDTH +: WIDTH]
- flags  out  NUM_CH*3  sticky {match,unf,ovf}, same layout
- dir  out  NUM_CH  ping-pong direction, 0 up
- done  out  NUM_CH  one-shot finished
- pwm_out  out  NUM_CH  count < compare
- irq  out  1  OR of (flags & irq_mask)

## Operation
- Prescaler: pre_cnt counts 0..prescale. tick=1 when pre_cnt==prescale, then pre_cnt<=0. Free-running, independent of enables. A prescale change takes effect at the next compare; if pre_cnt > new prescale, it counts up and wraps naturally.
- Channel advances on edge where tick && ch_enable[i] && !done[i]. Arithmetic uses WIDTH+1 bits; MAX = 2^WIDTH-1.
- Up: sum=count+step. If sum>MAX: ovf event, next = auto_reload ? reload : sum-2^WIDTH. Otherwise next=sum.
- Down: if count<step: unf event, next = auto_reload ? reload : count-step+2^WIDTH. Otherwise next=count-step.
- Ping-pong: saturates instead of wrapping. Going up with sum>MAX: next=MAX, ovf event, dir flips. Going down with count<step: next=0, unf event, dir flips. auto_reload is ignored.
- One-shot: if count≤step: next=0, unf event, done<=1, and the channel freezes. Otherwise next=count-step.
- step=0: count holds, no events, in all modes.
- Match: match event when next==compare on an advancing edge.
- Events set sticky flags. irq_clear bit clears its flag. If set and clear hit the same cycle, set wins.
- cfg_we writes mode/step/reload/compare/auto_reload of cfg_ch. A mode change also sets dir<=0 and done<=0. An advance in the same cycle uses the old config.
- load_we: count[cfg_ch]<=load_value, dir<=0, done<=0. Load beats a simultaneous advance of that channel, and no events fire for it. Other channels advance normally.
- Reset: all counts 0, mode 00, step 1, reload 0, compare 0, auto_reload 0, dir 0, done 0, flags 0, pre_cnt 0. Outputs after reset: count_flat 0, flags 0, dir 0, done 0, pwm_out 0, irq 0.

## Timing
- count, dir, done and flags update on the gated_clk edge of the triggering tick, and are visible the cycle after.
- pwm_out is combinational from registered count/compare, so it follows count with zero extra latency.
- irq is combinational from flags and irq_mask: high the cycle after the event edge, low the cycle after the clearing edge.
- Load and config become visible one cycle after the strobe.
- Asserting rst_n low mid-operation clears all state immediately, with no clock needed. The first tick after release comes prescale+1 edges later.

## Test plan
- prescale=2, ch0 up, step 3, load 250 → count 253 after 3 edges, then 0 after 3 more. ovf flag set; irq=1 with mask bit0 set.
- ch1 ping-pong, step 100, from 0 → 100, 200, 255 (ovf, dir=1), 155, 55, 0 (unf, dir=0), 100.
- ch2 one-shot, load 10, step 4 → 6, 2, 0; done=1 with unf; count stays 0 on later ticks. Then load 9 → done=0 and counting resumes.
- ch3 down, auto_reload=1, reload 50, step 5, load 3 → 50 with unf flag. irq_clear asserted on the same cycle as a new unf event → flag stays 1.
- load_we on ch1 coincident with a tick → count=load_value and no event. Ch0 advances in the same cycle. Compare=7 with count reaching 7 → match flag set, and pwm_out drops when count≥7.
- Reset asserted mid-count at prescale=3 → all outputs 0 immediately. First advance occurs 4 edges after release.
